vend_sequencer: RTL

//  Control FSM for the coffee vending machine. Accepts coins and accumulates credit up to a

---
 rtl/vend_pkg.sv | 23 ++
 rtl/change_picker.sv | 22 ++
 rtl/vend_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin definitions for the coffee vending sequencer.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CUP,
        BREW,
        CHANGE,
        DONE
    } state_e;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_2  = 4'd2;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    function automatic logic coin_legal(input logic [3:0] value);
        return (value == COIN_1) || (value == COIN_2) ||
               (value == COIN_5) || (value == COIN_10);
    endfunction

endpackage

// File: rtl/change_picker.sv
// Picks the largest returnable coin (5, 2 or 1) not exceeding the remaining credit.
module change_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [3:0]          change_value
);

    always_comb begin
        change_value = 4'd0;
        if (32'(credit) >= 32'(COIN_5)) begin
            change_value = COIN_5;
        end else if (32'(credit) >= 32'(COIN_2)) begin
            change_value = COIN_2;
        end else if (32'(credit) >= 32'(COIN_1)) begin
            change_value = COIN_1;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending control FSM: coin collection, cup/brew/change sequencing and status LEDs.
// Every output is a flop whose next value is derived from the next state.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int  PRICE       = 10,
    parameter int  CREDIT_MAX  = 31,
    parameter int  BREW_CYCLES = 8,
    parameter int  DONE_CYCLES = 4,
    localparam int CREDIT_W    = $clog2(CREDIT_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    output logic                coin_reject,
    input  logic                cancel,
    output logic                cup_drop,
    output logic                brew_on,
    output logic                change_valid,
    output logic [3:0]          change_value,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                led_yellow,
    output logic                led_green
);

    localparam int SUM_W   = (CREDIT_W + 1 > 5) ? CREDIT_W + 1 : 5;
    localparam int CNT_MAX = (BREW_CYCLES > DONE_CYCLES) ? BREW_CYCLES : DONE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                refund_q, refund_d;
    logic                coin_reject_q, coin_reject_d;
    logic                cup_drop_q, cup_drop_d;
    logic                brew_on_q, brew_on_d;
    logic                change_valid_q, change_valid_d;
    logic [3:0]          change_value_q, change_value_d;
    logic                led_yellow_q, led_yellow_d;
    logic                led_green_q, led_green_d;

    logic [SUM_W-1:0]    sum, total;
    logic                coin_take;
    logic [3:0]          pick_value;

    // The picker looks at next-cycle credit so a fresh coin is offered right after each ack.
    change_picker #(
        .CREDIT_W (CREDIT_W)
    ) u_change_picker (
        .credit       (credit_d),
        .change_value (pick_value)
    );

    always_comb begin
        sum       = SUM_W'(credit_q) + SUM_W'(coin_value);
        coin_take = coin_valid && (state_q == IDLE || state_q == COLLECT) &&
                    coin_legal(coin_value) && (sum <= SUM_W'(CREDIT_MAX));
        total     = coin_take ? sum : SUM_W'(credit_q);

        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        refund_d = refund_q;

        case (state_q)
            IDLE: begin
                if (coin_take) begin
                    state_d  = COLLECT;
                    credit_d = CREDIT_W'(total);
                end
            end
            COLLECT: begin
                credit_d = CREDIT_W'(total);
                if (cancel) begin
                    state_d  = CHANGE;
                    refund_d = 1'b1;
                end else if (total >= SUM_W'(PRICE)) begin
                    state_d  = CUP;
                    credit_d = CREDIT_W'(total - SUM_W'(PRICE));
                end
            end
            CUP: begin
                state_d = BREW;
                cnt_d   = CNT_W'(BREW_CYCLES - 1);
            end
            BREW: begin
                if (cnt_q == '0) begin
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                    end else begin
                        state_d = DONE;
                        cnt_d   = CNT_W'(DONE_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHANGE: begin
                if (change_valid_q && change_ack) begin
                    credit_d = credit_q - CREDIT_W'(change_value_q);
                end
                // A cancelled purchase skips the green "vend complete" indication.
                if (credit_d == '0) begin
                    refund_d = 1'b0;
                    if (refund_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        cnt_d   = CNT_W'(DONE_CYCLES - 1);
                    end
                end
            end
            DONE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        coin_reject_d  = coin_valid && !coin_take;
        cup_drop_d     = (state_d == CUP);
        brew_on_d      = (state_d == BREW);
        change_valid_d = (state_d == CHANGE);
        change_value_d = (state_d == CHANGE) ? pick_value : 4'd0;
        led_yellow_d   = (state_d == CUP) || (state_d == BREW) || (state_d == CHANGE);
        led_green_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            cnt_q          <= '0;
            refund_q       <= 1'b0;
            coin_reject_q  <= 1'b0;
            cup_drop_q     <= 1'b0;
            brew_on_q      <= 1'b0;
            change_valid_q <= 1'b0;
            change_value_q <= 4'd0;
            led_yellow_q   <= 1'b0;
            led_green_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            refund_q       <= refund_d;
            coin_reject_q  <= coin_reject_d;
            cup_drop_q     <= cup_drop_d;
            brew_on_q      <= brew_on_d;
            change_valid_q <= change_valid_d;
            change_value_q <= change_value_d;
            led_yellow_q   <= led_yellow_d;
            led_green_q    <= led_green_d;
        end
    end

    assign coin_reject  = coin_reject_q;
    assign cup_drop     = cup_drop_q;
    assign brew_on      = brew_on_q;
    assign change_valid = change_valid_q;
    assign change_value = change_value_q;
    assign credit       = credit_q;
    assign led_yellow   = led_yellow_q;
    assign led_green    = led_green_q;

endmodule
